// File: rtl/lc3_mmio.sv
// LC-3 memory-mapped I/O: keyboard status/data with a receive FIFO and a
// display status/data port with a single-byte valid/ready sender.
module lc3_mmio #(
    parameter int KB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic        io_sel,
    output logic [15:0] mem_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        kb_irq,
    output logic        disp_irq
);

    localparam int              PW       = $clog2(KB_DEPTH);
    localparam logic [PW:0]     FULL_CNT = (PW+1)'(KB_DEPTH);
    localparam logic [PW:0]     CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} disp_state_t;

    disp_state_t   state, next_state;

    logic [7:0]    fifo_mem [KB_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          kb_ie, kb_ovr;
    logic          disp_ie, disp_drop;

    logic hit_kbsr, hit_kbdr, hit_dsr, hit_ddr;
    logic rd_acc, wr_acc;
    logic nonempty, full, push, pop;
    logic state_idle;
    logic [7:0] kb_head;
    logic unused_wdata;

    // Address decode and access qualifiers
    assign hit_kbsr = mem_en && (mem_addr == 16'hFE00);
    assign hit_kbdr = mem_en && (mem_addr == 16'hFE02);
    assign hit_dsr  = mem_en && (mem_addr == 16'hFE04);
    assign hit_ddr  = mem_en && (mem_addr == 16'hFE06);
    assign io_sel   = hit_kbsr || hit_kbdr || hit_dsr || hit_ddr;
    assign rd_acc   = mem_en && !mem_we;
    assign wr_acc   = mem_en && mem_we;

    assign unused_wdata = ^{mem_wdata[15], mem_wdata[13:8]};

    assign nonempty = (count != '0);
    assign full     = (count == FULL_CNT);
    assign kb_ready = !full;
    assign push     = kb_valid && !full;
    assign pop      = rd_acc && hit_kbdr && nonempty;
    assign kb_head  = nonempty ? fifo_mem[rd_ptr] : 8'h00;

    // Storage array carries data only, so it is left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= kb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            kb_ie  <= 1'b0;
            kb_ovr <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (wr_acc && hit_kbsr) begin
                kb_ie <= mem_wdata[14];
                if (mem_wdata[0]) kb_ovr <= 1'b0;
            end
            // A dropped byte on the same edge as a clear still leaves the flag set
            if (kb_valid && full) kb_ovr <= 1'b1;
        end
    end

    // Display FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Display FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (wr_acc && hit_ddr) next_state = SEND;
            SEND:    if (disp_ready)        next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Display FSM: outputs
    always_comb begin
        disp_valid = (state == SEND);
        state_idle = (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_data <= 8'h00;
            disp_ie   <= 1'b0;
            disp_drop <= 1'b0;
        end else begin
            if (wr_acc && hit_dsr) begin
                disp_ie <= mem_wdata[14];
                if (mem_wdata[0]) disp_drop <= 1'b0;
            end
            if (wr_acc && hit_ddr) begin
                if (state_idle) disp_data <= mem_wdata[7:0];
                else            disp_drop <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_rdata = 16'h0000;
        if (rd_acc) begin
            if (hit_kbsr) mem_rdata = {nonempty, kb_ie, 13'b0, kb_ovr};
            if (hit_kbdr) mem_rdata = {8'h00, kb_head};
            if (hit_dsr)  mem_rdata = {state_idle, disp_ie, 13'b0, disp_drop};
        end
    end

    assign kb_irq   = kb_ie && nonempty;
    assign disp_irq = disp_ie && state_idle;

endmodule

// File: tb/tb_lc3_mmio.sv
// Scoreboard bench for lc3_mmio: register reads and display handshakes are
// checked by monitors against queued expectations; level outputs are probed.
module tb_lc3_mmio;

    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;
    localparam logic [15:0] DSR  = 16'hFE04;
    localparam logic [15:0] DDR  = 16'hFE06;

    logic        clk, rst;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        io_sel;
    logic [15:0] mem_rdata;
    logic        kb_valid, kb_ready;
    logic [7:0]  kb_data;
    logic        disp_valid, disp_ready;
    logic [7:0]  disp_data;
    logic        kb_irq, disp_irq;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t rq[$];
    exp_t dq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    lc3_mmio #(.KB_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .io_sel(io_sel), .mem_rdata(mem_rdata),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
        .kb_irq(kb_irq), .disp_irq(disp_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Read monitor: every device-register read is matched against the queue
    always @(negedge clk) begin
        if (mem_en && !mem_we && io_sel) begin
            if (rq.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got read of %h expected none", mem_addr);
            end else begin
                exp_t e;
                e = rq.pop_front();
                check16(e.name, mem_rdata, e.exp);
            end
        end
    end

    // Display monitor: every accepted byte is matched against the queue
    always @(negedge clk) begin
        if (disp_valid && disp_ready) begin
            if (dq.size() == 0) begin
                n_checks++;
                $display("FAIL disp_unexpected: got byte %h expected none", disp_data);
            end else begin
                exp_t e;
                e = dq.pop_front();
                check16(e.name, {8'h00, disp_data}, e.exp);
            end
        end
    end

    // All tasks start and end at 1 time unit after a rising edge
    task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        rq.push_back(e);
        mem_en = 1'b1; mem_we = 1'b0; mem_addr = addr;
        @(posedge clk); #1;
        mem_en = 1'b0;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        mem_en = 1'b1; mem_we = 1'b1; mem_addr = addr; mem_wdata = data;
        @(posedge clk); #1;
        mem_en = 1'b0; mem_we = 1'b0;
    endtask

    task automatic kb_push(input logic [7:0] b);
        kb_valid = 1'b1; kb_data = b;
        @(posedge clk); #1;
        kb_valid = 1'b0;
    endtask

    task automatic disp_accept(input logic [7:0] b, input string name);
        exp_t e;
        e.name = name;
        e.exp  = {8'h00, b};
        dq.push_back(e);
        disp_ready = 1'b1;
        @(posedge clk); #1;
        disp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        mem_en = 1'b0; mem_we = 1'b0; mem_addr = 16'h0000; mem_wdata = 16'h0000;
        kb_valid = 1'b0; kb_data = 8'h00; disp_ready = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check16("rst_kb_ready",   {15'b0, kb_ready},   16'h0001);
        check16("rst_disp_valid", {15'b0, disp_valid}, 16'h0000);
        check16("rst_kb_irq",     {15'b0, kb_irq},     16'h0000);
        check16("rst_disp_irq",   {15'b0, disp_irq},   16'h0000);
        rd(KBSR, 16'h0000, "rst_kbsr");
        rd(DSR,  16'h8000, "rst_dsr");
        mem_en = 1'b1; mem_addr = 16'hFE01; #1;
        check16("nohit_io_sel", {15'b0, io_sel}, 16'h0000);
        check16("nohit_rdata",  mem_rdata,       16'h0000);
        mem_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // Two bytes through the FIFO, then read on empty
        kb_push(8'h41);
        kb_push(8'h42);
        rd(KBSR, 16'h8000, "kbsr_two");
        rd(KBDR, 16'h0041, "kbdr_41");
        rd(KBDR, 16'h0042, "kbdr_42");
        rd(KBSR, 16'h0000, "kbsr_empty");
        rd(KBDR, 16'h0000, "kbdr_empty");
        rd(KBSR, 16'h0000, "kbsr_still_empty");

        // Fill, overflow, clear overflow, drain
        kb_push(8'h10);
        kb_push(8'h11);
        kb_push(8'h12);
        kb_push(8'h13);
        check16("full_kb_ready", {15'b0, kb_ready}, 16'h0000);
        kb_push(8'h14);
        rd(KBSR, 16'h8001, "kbsr_ovr");
        wr(KBSR, 16'h0001);
        rd(KBSR, 16'h8000, "kbsr_ovr_clr");
        rd(KBDR, 16'h0010, "drain_10");
        rd(KBDR, 16'h0011, "drain_11");
        rd(KBDR, 16'h0012, "drain_12");
        rd(KBDR, 16'h0013, "drain_13");
        rd(KBSR, 16'h0000, "kbsr_drained");

        // Simultaneous push and pop keeps order and count
        kb_push(8'h20);
        kb_valid = 1'b1; kb_data = 8'h21;
        rd(KBDR, 16'h0020, "pushpop_20");
        kb_valid = 1'b0;
        rd(KBSR, 16'h8000, "pushpop_kbsr");
        rd(KBDR, 16'h0021, "pushpop_21");
        rd(KBSR, 16'h0000, "pushpop_empty");

        // Keyboard interrupt follows FIFO occupancy
        kb_push(8'h55);
        wr(KBSR, 16'h4000);
        check16("kb_irq_on", {15'b0, kb_irq}, 16'h0001);
        rd(KBSR, 16'hC000, "kbsr_ie");
        rd(KBDR, 16'h0055, "kbdr_55");
        check16("kb_irq_off", {15'b0, kb_irq}, 16'h0000);
        wr(KBSR, 16'h0000);
        wr(KBDR, 16'h00FF);
        rd(KBSR, 16'h0000, "kbdr_write_noop");

        // Display send and acceptance
        wr(DDR, 16'h0048);
        check16("send_valid", {15'b0, disp_valid}, 16'h0001);
        check16("send_data",  {8'h00, disp_data},  16'h0048);
        rd(DSR, 16'h0000, "dsr_busy");
        rd(DDR, 16'h0000, "ddr_read_zero");
        disp_accept(8'h48, "disp_48");
        rd(DSR, 16'h8000, "dsr_idle");
        check16("idle_valid", {15'b0, disp_valid}, 16'h0000);

        // Store during SEND is dropped
        wr(DDR, 16'h0048);
        wr(DDR, 16'h0049);
        rd(DSR, 16'h0001, "dsr_drop");
        check16("drop_data_held", {8'h00, disp_data}, 16'h0048);
        disp_accept(8'h48, "disp_48_again");
        rd(DSR, 16'h8001, "dsr_idle_drop");
        wr(DSR, 16'h0001);
        rd(DSR, 16'h8000, "dsr_drop_clr");

        // Display interrupt while idle
        wr(DSR, 16'h4000);
        check16("disp_irq_on", {15'b0, disp_irq}, 16'h0001);
        rd(DSR, 16'hC000, "dsr_ie");
        wr(DSR, 16'h0000);
        check16("disp_irq_off", {15'b0, disp_irq}, 16'h0000);

        // Reset asserted between edges while sending
        kb_push(8'h66);
        wr(DDR, 16'h005A);
        check16("pre_rst_valid", {15'b0, disp_valid}, 16'h0001);
        #2 rst = 1'b0;
        #1;
        check16("async_rst_valid", {15'b0, disp_valid}, 16'h0000);
        check16("async_rst_ready", {15'b0, kb_ready},   16'h0001);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rd(DSR,  16'h8000, "post_rst_dsr");
        rd(KBSR, 16'h0000, "post_rst_kbsr");

        repeat (2) @(posedge clk);
        #1;
        check16("rq_drained", 16'(rq.size()), 16'h0000);
        check16("dq_drained", 16'(dq.size()), 16'h0000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
